// File: rtl/register_file_pkg.sv
// Shared definitions used by the register file, reorder buffer and decoder.
package register_file_pkg;

  localparam int REG_WIDTH  = 5;
  localparam int DATA_WIDTH = 32;
  localparam int ROB_WIDTH  = 4;

  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = 32'h0000_0000;
  localparam logic [ROB_WIDTH-1:0]  ZERO_ROB  = 4'h0;

  typedef logic [REG_WIDTH-1:0]  reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/register_file.sv
// Architectural register file with rename tracking (busy bit + ROB tag per
// register) and a same-cycle commit bypass on both read ports.
module register_file
  import register_file_pkg::*;
#(
  parameter int REG_NUM   = 32,
  parameter int ROB_TAG_W = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic [4:0]           rob2reg_rs1_request,
  input  logic [4:0]           rob2reg_rs2_request,
  output logic [31:0]          reg2rob_rs1_value,
  output logic [31:0]          reg2rob_rs2_value,
  output logic [ROB_TAG_W-1:0] reg2rob_rs1_rename,
  output logic [ROB_TAG_W-1:0] reg2rob_rs2_rename,
  output logic                 reg2rob_rs1_if_rename,
  output logic                 reg2rob_rs2_if_rename,
  input  logic                 rob2reg_rd_enable,
  input  logic [4:0]           rob2reg_rd_request,
  input  logic [ROB_TAG_W-1:0] rob2reg_rd_reorder,
  input  logic                 rob2reg_commit_enable,
  input  logic [4:0]           rob2reg_commit_des,
  input  logic [31:0]          rob2reg_commit_value,
  input  logic [ROB_TAG_W-1:0] rob2reg_commit_reorder,
  input  logic                 rob2reg_flush
);

  typedef struct packed {
    logic [31:0]          value;
    logic [ROB_TAG_W-1:0] rename;
    logic                 if_rename;
  } read_t;

  data_t                reg_value [REG_NUM];
  logic                 reg_busy  [REG_NUM];
  logic [ROB_TAG_W-1:0] reg_tag   [REG_NUM];

  read_t rs1_read;
  read_t rs2_read;

  // Resolve one read port: x0 is hard zero, a matching in-flight commit is
  // forwarded, otherwise the stored value and rename state are returned.
  function automatic read_t read_port(
    input logic [4:0]           rs,
    input data_t                val,
    input logic                 bsy,
    input logic [ROB_TAG_W-1:0] tg,
    input logic                 c_en,
    input logic [4:0]           c_des,
    input data_t                c_val,
    input logic [ROB_TAG_W-1:0] c_tag
  );
    read_t r;
    if (rs == 5'd0) begin
      r.value     = ZERO_DATA;
      r.rename    = {ROB_TAG_W{1'b0}};
      r.if_rename = 1'b0;
    end else if (c_en && (c_des == rs) && bsy && (tg == c_tag)) begin
      r.value     = c_val;
      r.rename    = {ROB_TAG_W{1'b0}};
      r.if_rename = 1'b0;
    end else begin
      r.value     = val;
      r.rename    = bsy ? tg : {ROB_TAG_W{1'b0}};
      r.if_rename = bsy;
    end
    return r;
  endfunction

  // Zero-latency read ports built from the same resolve function.
  always_comb begin
    rs1_read = read_port(rob2reg_rs1_request,
                         reg_value[rob2reg_rs1_request],
                         reg_busy[rob2reg_rs1_request],
                         reg_tag[rob2reg_rs1_request],
                         rob2reg_commit_enable, rob2reg_commit_des,
                         rob2reg_commit_value, rob2reg_commit_reorder);
    rs2_read = read_port(rob2reg_rs2_request,
                         reg_value[rob2reg_rs2_request],
                         reg_busy[rob2reg_rs2_request],
                         reg_tag[rob2reg_rs2_request],
                         rob2reg_commit_enable, rob2reg_commit_des,
                         rob2reg_commit_value, rob2reg_commit_reorder);
  end

  assign reg2rob_rs1_value     = rs1_read.value;
  assign reg2rob_rs1_rename    = rs1_read.rename;
  assign reg2rob_rs1_if_rename = rs1_read.if_rename;
  assign reg2rob_rs2_value     = rs2_read.value;
  assign reg2rob_rs2_rename    = rs2_read.rename;
  assign reg2rob_rs2_if_rename = rs2_read.if_rename;

  // State update: reset dominates; when ready, commits write the value,
  // flush clears every busy bit, and a rename overrides a same-register
  // commit clear (statement order gives the rename priority).
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        reg_value[i] <= ZERO_DATA;
        reg_busy[i]  <= 1'b0;
        reg_tag[i]   <= {ROB_TAG_W{1'b0}};
      end
    end else if (rdy_in) begin
      if (rob2reg_commit_enable && (rob2reg_commit_des != 5'd0)) begin
        reg_value[rob2reg_commit_des] <= rob2reg_commit_value;
      end
      if (rob2reg_flush) begin
        for (int i = 0; i < REG_NUM; i++) begin
          reg_busy[i] <= 1'b0;
        end
      end else begin
        if (rob2reg_commit_enable && (rob2reg_commit_des != 5'd0) &&
            (reg_tag[rob2reg_commit_des] == rob2reg_commit_reorder)) begin
          reg_busy[rob2reg_commit_des] <= 1'b0;
        end
        if (rob2reg_rd_enable && (rob2reg_rd_request != 5'd0)) begin
          reg_busy[rob2reg_rd_request] <= 1'b1;
          reg_tag[rob2reg_rd_request]  <= rob2reg_rd_reorder;
        end
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: expected read results are queued
// when a read is requested and compared once the ports have settled.
module tb_register_file;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [4:0]  rob2reg_rs1_request, rob2reg_rs2_request;
  logic [31:0] reg2rob_rs1_value, reg2rob_rs2_value;
  logic [3:0]  reg2rob_rs1_rename, reg2rob_rs2_rename;
  logic        reg2rob_rs1_if_rename, reg2rob_rs2_if_rename;
  logic        rob2reg_rd_enable;
  logic [4:0]  rob2reg_rd_request;
  logic [3:0]  rob2reg_rd_reorder;
  logic        rob2reg_commit_enable;
  logic [4:0]  rob2reg_commit_des;
  logic [31:0] rob2reg_commit_value;
  logic [3:0]  rob2reg_commit_reorder;
  logic        rob2reg_flush;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] value;
    logic        if_rename;
    logic [3:0]  rename;
  } exp_t;

  exp_t exp_q[$];

  register_file #(.REG_NUM(32), .ROB_TAG_W(4)) dut (
    .clk_in                 (clk_in),
    .rst_in                 (rst_in),
    .rdy_in                 (rdy_in),
    .rob2reg_rs1_request    (rob2reg_rs1_request),
    .rob2reg_rs2_request    (rob2reg_rs2_request),
    .reg2rob_rs1_value      (reg2rob_rs1_value),
    .reg2rob_rs2_value      (reg2rob_rs2_value),
    .reg2rob_rs1_rename     (reg2rob_rs1_rename),
    .reg2rob_rs2_rename     (reg2rob_rs2_rename),
    .reg2rob_rs1_if_rename  (reg2rob_rs1_if_rename),
    .reg2rob_rs2_if_rename  (reg2rob_rs2_if_rename),
    .rob2reg_rd_enable      (rob2reg_rd_enable),
    .rob2reg_rd_request     (rob2reg_rd_request),
    .rob2reg_rd_reorder     (rob2reg_rd_reorder),
    .rob2reg_commit_enable  (rob2reg_commit_enable),
    .rob2reg_commit_des     (rob2reg_commit_des),
    .rob2reg_commit_value   (rob2reg_commit_value),
    .rob2reg_commit_reorder (rob2reg_commit_reorder),
    .rob2reg_flush          (rob2reg_flush)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic quiet();
    rob2reg_rd_enable     = 1'b0;
    rob2reg_commit_enable = 1'b0;
    rob2reg_flush         = 1'b0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [3:0] t);
    rob2reg_rd_enable  = 1'b1;
    rob2reg_rd_request = rd;
    rob2reg_rd_reorder = t;
  endtask

  task automatic commit(input logic [4:0] d, input logic [3:0] t, input logic [31:0] v);
    rob2reg_commit_enable  = 1'b1;
    rob2reg_commit_des     = d;
    rob2reg_commit_reorder = t;
    rob2reg_commit_value   = v;
  endtask

  // Pop every queued expectation and compare it with the matching port.
  task automatic collect();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.port == 1) begin
        check_eq({e.tag, "/rs1.value"}, reg2rob_rs1_value, e.value);
        check_eq({e.tag, "/rs1.if_rename"}, {31'd0, reg2rob_rs1_if_rename}, {31'd0, e.if_rename});
        check_eq({e.tag, "/rs1.rename"}, {28'd0, reg2rob_rs1_rename}, {28'd0, e.rename});
      end else begin
        check_eq({e.tag, "/rs2.value"}, reg2rob_rs2_value, e.value);
        check_eq({e.tag, "/rs2.if_rename"}, {31'd0, reg2rob_rs2_if_rename}, {31'd0, e.if_rename});
        check_eq({e.tag, "/rs2.rename"}, {28'd0, reg2rob_rs2_rename}, {28'd0, e.rename});
      end
    end
  endtask

  // Request a read on both ports, queue the expectations, then let the
  // combinational outputs settle and score them.
  task automatic read_pair(input string tag,
                           input logic [4:0] a, input logic [31:0] av, input logic ai, input logic [3:0] ar,
                           input logic [4:0] b, input logic [31:0] bv, input logic bi, input logic [3:0] br);
    exp_t e;
    rob2reg_rs1_request = a;
    rob2reg_rs2_request = b;
    e.tag = tag; e.port = 1; e.value = av; e.if_rename = ai; e.rename = ar;
    exp_q.push_back(e);
    e.port = 2; e.value = bv; e.if_rename = bi; e.rename = br;
    exp_q.push_back(e);
    #1;
    collect();
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    rob2reg_rs1_request = 5'd0;
    rob2reg_rs2_request = 5'd0;
    rob2reg_rd_request = 5'd0;
    rob2reg_rd_reorder = 4'd0;
    rob2reg_commit_des = 5'd0;
    rob2reg_commit_value = 32'd0;
    rob2reg_commit_reorder = 4'd0;
    quiet();
    tick();
    tick();
    rst_in = 1'b0;

    // Reset state
    read_pair("reset", 5'd5, 32'd0, 1'b0, 4'd0, 5'd0, 32'd0, 1'b0, 4'd0);

    // Rename, then commit with matching tag (bypass)
    rename(5'd3, 4'd7);
    tick();
    quiet();
    read_pair("ren_x3", 5'd3, 32'd0, 1'b1, 4'd7, 5'd3, 32'd0, 1'b1, 4'd7);
    commit(5'd3, 4'd7, 32'hDEADBEEF);
    read_pair("bypass_x3", 5'd3, 32'hDEADBEEF, 1'b0, 4'd0, 5'd5, 32'd0, 1'b0, 4'd0);
    tick();
    quiet();
    read_pair("commit_x3", 5'd3, 32'hDEADBEEF, 1'b0, 4'd0, 5'd0, 32'd0, 1'b0, 4'd0);

    // Stale-tag commit: value written, busy and new tag kept
    rename(5'd4, 4'd2);
    tick();
    rename(5'd4, 4'd9);
    tick();
    quiet();
    commit(5'd4, 4'd2, 32'h11);
    read_pair("stale_same", 5'd4, 32'd0, 1'b1, 4'd9, 5'd3, 32'hDEADBEEF, 1'b0, 4'd0);
    tick();
    quiet();
    read_pair("stale_after", 5'd4, 32'h11, 1'b1, 4'd9, 5'd4, 32'h11, 1'b1, 4'd9);

    // Rename and commit of the old tag to the same register: rename wins
    rename(5'd6, 4'd3);
    tick();
    rename(5'd6, 4'd5);
    commit(5'd6, 4'd3, 32'h66);
    read_pair("ren_vs_commit_same", 5'd6, 32'h66, 1'b0, 4'd0, 5'd4, 32'h11, 1'b1, 4'd9);
    tick();
    quiet();
    read_pair("ren_vs_commit", 5'd6, 32'h66, 1'b1, 4'd5, 5'd6, 32'h66, 1'b1, 4'd5);

    // Flush with a simultaneous commit and rename
    rename(5'd1, 4'd1);
    tick();
    rename(5'd2, 4'd2);
    tick();
    rename(5'd31, 4'd15);
    tick();
    quiet();
    read_pair("pre_flush", 5'd1, 32'd0, 1'b1, 4'd1, 5'd31, 32'd0, 1'b1, 4'd15);
    rob2reg_flush = 1'b1;
    commit(5'd1, 4'd8, 32'h42);
    rename(5'd8, 4'd4);
    tick();
    quiet();
    read_pair("flush_a", 5'd1, 32'h42, 1'b0, 4'd0, 5'd2, 32'd0, 1'b0, 4'd0);
    read_pair("flush_b", 5'd31, 32'd0, 1'b0, 4'd0, 5'd8, 32'd0, 1'b0, 4'd0);
    read_pair("flush_c", 5'd4, 32'h11, 1'b0, 4'd0, 5'd6, 32'h66, 1'b0, 4'd0);

    // Stall freezes all state, bypass still visible
    rename(5'd12, 4'd3);
    tick();
    quiet();
    rdy_in = 1'b0;
    rob2reg_flush = 1'b1;
    rename(5'd9, 4'd6);
    commit(5'd12, 4'd3, 32'h77);
    read_pair("stall_bypass", 5'd12, 32'h77, 1'b0, 4'd0, 5'd9, 32'd0, 1'b0, 4'd0);
    tick();
    commit(5'd10, 4'd0, 32'h1234);
    tick();
    quiet();
    read_pair("stall_a", 5'd12, 32'd0, 1'b1, 4'd3, 5'd9, 32'd0, 1'b0, 4'd0);
    read_pair("stall_b", 5'd10, 32'd0, 1'b0, 4'd0, 5'd0, 32'd0, 1'b0, 4'd0);
    rdy_in = 1'b1;

    // x0 ignores renames and writes
    rename(5'd0, 4'd5);
    commit(5'd0, 4'd0, 32'h55);
    read_pair("x0_same", 5'd0, 32'd0, 1'b0, 4'd0, 5'd0, 32'd0, 1'b0, 4'd0);
    tick();
    quiet();
    read_pair("x0_after", 5'd0, 32'd0, 1'b0, 4'd0, 5'd12, 32'd0, 1'b1, 4'd3);

    // Plain commits to idle registers across a range
    for (int i = 16; i < 24; i++) begin
      commit(5'(i), 4'd0, i * 32'h01010101);
      tick();
    end
    quiet();
    for (int i = 16; i < 24; i += 2) begin
      read_pair("bulk", 5'(i), i * 32'h01010101, 1'b0, 4'd0,
                5'(i + 1), (i + 1) * 32'h01010101, 1'b0, 4'd0);
    end

    // Reset overrides flush, commit and rename, even while stalled
    rdy_in = 1'b0;
    rst_in = 1'b1;
    rob2reg_flush = 1'b1;
    commit(5'd3, 4'd0, 32'hAA);
    rename(5'd13, 4'd1);
    tick();
    quiet();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    read_pair("reset_override", 5'd3, 32'd0, 1'b0, 4'd0, 5'd13, 32'd0, 1'b0, 4'd0);
    read_pair("reset_clears", 5'd12, 32'd0, 1'b0, 4'd0, 5'd16, 32'd0, 1'b0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter REG_NUM, default 32: architectural register count.
REQ-002 SHALL have parameter ROB_TAG_W, default 4: ROB tag width, giving 16 ROB entries.
REQ-003 SHALL have port clk_in, input, 1: the single clock.
REQ-004 SHALL have port rst_in, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port rdy_in, input, 1: global stall; low freezes all state.
REQ-006 SHALL have ports rob2reg_rs1_request and rob2reg_rs2_request, input, 5 each: source register indices.
REQ-007 SHALL have ports reg2rob_rs1_value and reg2rob_rs2_value, output, 32 each: architectural values.
REQ-008 SHALL have ports reg2rob_rs1_rename and reg2rob_rs2_rename, output, ROB_TAG_W each: pending producer tags.
REQ-009 SHALL have ports reg2rob_rs1_if_rename and reg2rob_rs2_if_rename, output, 1 each: source awaits a ROB result.
REQ-010 SHALL have port rob2reg_rd_enable, input, 1: allocate a rename this cycle.
REQ-011 SHALL have port rob2reg_rd_request, input, 5: destination index to rename.
REQ-012 SHALL have port rob2reg_rd_reorder, input, ROB_TAG_W: ROB tag assigned to the destination.
REQ-013 SHALL have port rob2reg_commit_enable, input, 1: commit strobe.
REQ-014 SHALL have port rob2reg_commit_des, input, 5: commit destination index.
REQ-015 SHALL have port rob2reg_commit_value, input, 32: commit data.
REQ-016 SHALL have port rob2reg_commit_reorder, input, ROB_TAG_W: tag of the committing entry.
REQ-017 SHALL have port rob2reg_flush, input, 1: misprediction flush; clears all renames.

Function
REQ-018 SHALL hold per register: value[31:0], busy bit, tag[ROB_TAG_W-1:0].
REQ-019 SHALL drive read outputs combinationally (zero latency) from current state plus the same-cycle commit bypass.
REQ-020 Read, default: value is value[rs]; if_rename is busy[rs]; rename is tag[rs] when busy, else 0.
REQ-021 Read bypass: when commit_enable, commit_des == rs, rs != 0, busy[rs], and tag[rs] == commit_reorder, the read SHALL return commit_value with if_rename = 0 and rename = 0.
REQ-022 Register x0 SHALL read value 0 and if_rename 0 always; writes and renames to x0 SHALL be ignored.
REQ-023 On a rising edge with rdy_in = 1 and commit_enable = 1, value[commit_des] SHALL be written with commit_value, whether or not the register is busy.
REQ-024 In the same commit, busy[commit_des] SHALL clear only if tag[commit_des] == commit_reorder; a stale tag leaves busy and tag unchanged.
REQ-025 On a rising edge with rdy_in = 1 and rd_enable = 1, busy[rd] SHALL be set to 1 and tag[rd] set to rd_reorder.
REQ-026 When rename and commit hit the same register in one cycle, the rename SHALL win: busy stays 1 with the new tag, and the value is still written.
REQ-027 On flush with rdy_in = 1, all busy bits SHALL clear at the edge. A same-cycle commit write still occurs. A same-cycle rename is discarded.
REQ-028 With rdy_in = 0, no state SHALL change; outputs still track the inputs combinationally.
REQ-029 SHALL not validate tags against ROB occupancy; the ROB guarantees tag uniqueness.

Reset
REQ-030 At a rising edge with rst_in = 1, all value, busy and tag bits SHALL become 0, regardless of rdy_in.
REQ-031 Reset SHALL override flush, commit and rename in the same cycle.
REQ-032 After reset, every read output SHALL be 0 and every if_rename output SHALL be 0.

Structure
REQ-033 REG_WIDTH (4:0), DATA_WIDTH (31:0), ROB_WIDTH, ZERO_DATA and ZERO_ROB SHALL live in the shared definitions file, common with the reorder buffer and decoder.
REQ-034 SHALL be a single module without sub-modules, built from three REG_NUM-entry arrays.
REQ-035 The two read ports SHALL be identical logic; a per-port function or generate is permitted.

Verification
REQ-036 Reset, then read x5 and x0 -> value 0, if_rename 0, rename 0 on both ports.
REQ-037 Rename x3 with tag 7. Next cycle read x3 -> if_rename 1, rename 7. Then commit x3 with tag 7, value 0xDEADBEEF -> same-cycle read returns 0xDEADBEEF with if_rename 0. Following cycle: busy 0, value 0xDEADBEEF.
REQ-038 Rename x4 with tag 2, then rename x4 with tag 9, then commit x4 with tag 2, value 0x11 -> value 0x11, busy 1, rename 9.
REQ-039 Same cycle: rename x6 with tag 5 and commit x6 with the old tag -> next cycle busy 1, rename 5, value updated.
REQ-040 Rename x1, x2 and x31, then flush with a simultaneous commit of x1 (value 0x42) and a rename of x8 -> all if_rename 0, x1 = 0x42, x8 not busy.
REQ-041 With rdy_in = 0, rename x9 and commit x10 -> no state change. Then rename x0 and commit x0 with value 0x55 with rdy_in = 1 -> x0 still reads 0 with if_rename 0.
